local_net_iface: RTL



---
 rtl/local_net_iface.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/local_net_iface.sv
// Adapter between a processing element and a mesh router's local port.
// Buffers and serialises injected flits, and deserialises ejected flits behind a valid/ready handshake.
module local_net_iface #(
  parameter int ROUTER_ID    = 0,
  parameter int ADDR_BITS    = 4,
  parameter int PAYLOAD_SIZE = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic [ADDR_BITS-1:0]    src_dest,
  input  logic [PAYLOAD_SIZE-1:0] src_payload,
  output logic                    net_tx_data,
  input  logic                    net_tx_busy,
  input  logic                    net_rx_data,
  output logic                    net_rx_busy,
  output logic                    sink_valid,
  input  logic                    sink_ready,
  output logic [ADDR_BITS-1:0]    sink_dest,
  output logic [PAYLOAD_SIZE-1:0] sink_payload,
  output logic [15:0]             inj_count,
  output logic [15:0]             ej_count,
  output logic                    dest_err
);

  localparam int W  = PAYLOAD_SIZE + ADDR_BITS;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = $clog2(W);

  localparam logic [AW:0]           FIFO_FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]           CNT_ONE       = (AW+1)'(1);
  localparam logic [AW-1:0]         PTR_ONE       = AW'(1);
  localparam logic [BW-1:0]         LAST_BIT      = BW'(W - 1);
  localparam logic [BW-1:0]         BIT_ONE       = BW'(1);
  localparam logic [ADDR_BITS-1:0]  MY_ID         = ADDR_BITS'(ROUTER_ID);
  localparam logic [15:0]           CNT16_ONE     = 16'd1;

  // ------------------------------------------------------------------
  // Injection FIFO
  // ------------------------------------------------------------------
  logic [W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   fifo_count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;

  assign fifo_full  = (fifo_count_reg == FIFO_FULL_LVL);
  assign fifo_empty = (fifo_count_reg == '0);
  assign src_ready  = ~fifo_full;
  assign fifo_push  = src_valid & ~fifo_full;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= {src_payload, src_dest};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // TX serialiser. The line register lags the state by one cycle, which
  // gives the two-cycle write-to-start latency and W+3 frame spacing.
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  tx_state_t     tx_state_reg;
  logic [W-1:0]  tx_shreg_reg;
  logic [BW-1:0] tx_bit_reg;
  logic          tx_line_reg;
  logic [15:0]   inj_cnt_reg;

  assign fifo_pop = (tx_state_reg == TX_IDLE) & ~fifo_empty & ~net_tx_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_shreg_reg <= '0;
      tx_bit_reg   <= '0;
      tx_line_reg  <= 1'b0;
      inj_cnt_reg  <= '0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_line_reg <= 1'b0;
          if (fifo_pop) begin
            tx_shreg_reg <= fifo_mem[rd_ptr_reg];
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          tx_line_reg  <= 1'b1;
          tx_bit_reg   <= '0;
          tx_state_reg <= TX_SHIFT;
        end
        TX_SHIFT: begin
          tx_line_reg  <= tx_shreg_reg[0];
          tx_shreg_reg <= tx_shreg_reg >> 1;
          if (tx_bit_reg == LAST_BIT) begin
            tx_state_reg <= TX_GAP;
          end else begin
            tx_bit_reg <= tx_bit_reg + BIT_ONE;
          end
        end
        TX_GAP: begin
          tx_line_reg  <= 1'b0;
          inj_cnt_reg  <= inj_cnt_reg + CNT16_ONE;
          tx_state_reg <= TX_IDLE;
        end
        default: begin
          tx_line_reg  <= 1'b0;
          tx_state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  assign net_tx_data = tx_line_reg;
  assign inj_count   = inj_cnt_reg;

  // ------------------------------------------------------------------
  // RX deserialiser and sink handshake
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_HOLD
  } rx_state_t;

  rx_state_t             rx_state_reg;
  logic [W-1:0]          rx_shreg_reg;
  logic [W-1:0]          rx_shreg_next;
  logic [BW-1:0]         rx_bit_reg;
  logic                  rx_busy_reg;
  logic                  sink_valid_reg;
  logic [ADDR_BITS-1:0]  sink_dest_reg;
  logic [PAYLOAD_SIZE-1:0] sink_payload_reg;
  logic [15:0]           ej_cnt_reg;
  logic                  dest_err_reg;

  assign rx_shreg_next = {net_rx_data, rx_shreg_reg[W-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg     <= RX_IDLE;
      rx_shreg_reg     <= '0;
      rx_bit_reg       <= '0;
      rx_busy_reg      <= 1'b0;
      sink_valid_reg   <= 1'b0;
      sink_dest_reg    <= '0;
      sink_payload_reg <= '0;
      ej_cnt_reg       <= '0;
      dest_err_reg     <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (net_rx_data) begin
            rx_busy_reg  <= 1'b1;
            rx_bit_reg   <= '0;
            rx_state_reg <= RX_RECV;
          end
        end
        RX_RECV: begin
          rx_shreg_reg <= rx_shreg_next;
          if (rx_bit_reg == LAST_BIT) begin
            sink_valid_reg   <= 1'b1;
            sink_dest_reg    <= rx_shreg_next[ADDR_BITS-1:0];
            sink_payload_reg <= rx_shreg_next[W-1:ADDR_BITS];
            rx_state_reg     <= RX_HOLD;
          end else begin
            rx_bit_reg <= rx_bit_reg + BIT_ONE;
          end
        end
        RX_HOLD: begin
          // Line activity here would be a router protocol error and is ignored.
          if (sink_ready) begin
            sink_valid_reg <= 1'b0;
            rx_busy_reg    <= 1'b0;
            ej_cnt_reg     <= ej_cnt_reg + CNT16_ONE;
            if (sink_dest_reg != MY_ID) begin
              dest_err_reg <= 1'b1;
            end
            rx_state_reg <= RX_IDLE;
          end
        end
        default: begin
          rx_busy_reg    <= 1'b0;
          sink_valid_reg <= 1'b0;
          rx_state_reg   <= RX_IDLE;
        end
      endcase
    end
  end

  assign net_rx_busy  = rx_busy_reg;
  assign sink_valid   = sink_valid_reg;
  assign sink_dest    = sink_dest_reg;
  assign sink_payload = sink_payload_reg;
  assign ej_count     = ej_cnt_reg;
  assign dest_err     = dest_err_reg;

endmodule
